// File: rtl/spi_mem_pkg.sv
// Shared command codes and controller states for the SPI memory master.
package spi_mem_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP
  } state_t;

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit serialiser: SCLK divider, bit counter, MSB-first TX and RX shift registers.
module spi_bit_engine #(
  parameter int unsigned NB_MAX  = 64,
  parameter int unsigned RX_W    = 32,
  parameter int unsigned CLK_DIV = 1,
  localparam int unsigned CNT_W  = $clog2(NB_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  nbits,
  input  logic [NB_MAX-1:0] tx,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [RX_W-1:0]   rx,
  output logic              done_c
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

  logic              busy;
  logic [DIV_W-1:0]  div_cnt;
  logic [CNT_W-1:0]  bits_left;
  logic [NB_MAX-1:0] tx_sr;
  logic              phase_end_c;

  assign phase_end_c = busy && (div_cnt == DIV_W'(CLK_DIV - 1));
  // Fires on the edge that closes the high phase of the last bit.
  assign done_c      = phase_end_c && sclk && (bits_left == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      div_cnt   <= '0;
      bits_left <= '0;
      tx_sr     <= '0;
      rx        <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= tx[NB_MAX-1];
      tx_sr     <= {tx[NB_MAX-2:0], 1'b0};
      div_cnt   <= '0;
      bits_left <= nbits;
      rx        <= '0;
    end else if (busy) begin
      if (!phase_end_c) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
        if (!sclk) begin
          // Rising SCLK: sample the bit the slave presented during the low phase.
          sclk <= 1'b1;
          rx   <= {rx[RX_W-2:0], miso};
        end else begin
          sclk <= 1'b0;
          if (done_c) begin
            busy <= 1'b0;
            mosi <= 1'b0;
          end else begin
            bits_left <= bits_left - CNT_W'(1);
            mosi      <= tx_sr[NB_MAX-1];
            tx_sr     <= {tx_sr[NB_MAX-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_mem_master.sv
// SPI mode-0 memory master: validates requests, drives chip selects and
// returns read data from 0x03/0x02 transactions on a shared bus.
module spi_mem_master
  import spi_mem_pkg::*;
#(
  parameter int unsigned NUM_CS    = 2,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CLK_DIV   = 1,
  localparam int unsigned CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int unsigned LEN_W    = $clog2(MAX_BYTES + 1),
  localparam int unsigned DATA_W   = 8 * MAX_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [CS_W-1:0]   req_cs,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int unsigned NB_MAX = 8 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W  = $clog2(NB_MAX + 1);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic              write_q;
  logic              accept_c;
  logic              bad_c;
  logic              start_c;
  logic              done_c;
  logic [CNT_W-1:0]  nbits_c;
  logic [NB_MAX-1:0] tx_c;
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] rdata_c;

  assign accept_c = req_valid && req_ready;
  assign bad_c    = (req_len == '0) || (32'(req_len) > MAX_BYTES) || (32'(req_cs) >= NUM_CS);
  assign start_c  = accept_c && !bad_c;
  assign nbits_c  = CNT_W'(8 + ADDR_W) + (CNT_W'(req_len) << 3);

  // Transmit frame, left aligned: command, address, then data bytes 0..len-1.
  always_comb begin
    tx_c = '0;
    tx_c[NB_MAX-1 -: 8]      = req_write ? CMD_WRITE : CMD_READ;
    tx_c[NB_MAX-9 -: ADDR_W] = req_addr;
    if (req_write) begin
      for (int k = 0; k < int'(MAX_BYTES); k++) begin
        tx_c[DATA_W-1-8*k -: 8] = req_wdata[8*k +: 8];
      end
    end
  end

  // The last received byte sits lowest in rx; reorder so byte k lands at [8k+7:8k].
  always_comb begin
    rdata_c = '0;
    if (!write_q) begin
      for (int k = 0; k < int'(MAX_BYTES); k++) begin
        if (k < int'(len_q)) begin
          rdata_c[8*k +: 8] = rx[8*(int'(len_q)-1-k) +: 8];
        end
      end
    end
  end

  spi_bit_engine #(
    .NB_MAX  (NB_MAX),
    .RX_W    (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk    (clk),
    .rst    (rst),
    .start  (start_c),
    .nbits  (nbits_c),
    .tx     (tx_c),
    .miso   (miso),
    .sclk   (sclk),
    .mosi   (mosi),
    .rx     (rx),
    .done_c (done_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      cs_n      <= '1;
      len_q     <= '0;
      write_q   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            req_ready <= 1'b0;
            if (bad_c) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state   <= SHIFT;
              cs_n    <= ~(NUM_CS'(1) << req_cs);
              len_q   <= req_len;
              write_q <= req_write;
            end
          end
        end
        SHIFT: begin
          if (done_c) begin
            state     <= RESP;
            cs_n      <= '1;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= rdata_c;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          cs_n      <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: two instances (CLK_DIV=1/NUM_CS=2 and CLK_DIV=3/NUM_CS=3)
// behind one SPI slave model, request table plus scoreboard of expected responses.
module tb_spi_mem_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_write, miso, sel;
  logic [1:0]  req_cs;
  logic [23:0] req_addr;
  logic [2:0]  req_len;
  logic [31:0] req_wdata;

  logic        ready1, rv1, err1, sclk1, mosi1;
  logic [31:0] rdata1;
  logic [1:0]  cs_n1;
  logic        ready3, rv3, err3, sclk3, mosi3;
  logic [31:0] rdata3;
  logic [2:0]  cs_n3;

  logic        ready_m, rv_m, err_m, sclk_m, mosi_m;
  logic [31:0] rdata_m;
  logic [2:0]  cs_n_m;

  assign ready_m = sel ? ready3 : ready1;
  assign rv_m    = sel ? rv3    : rv1;
  assign err_m   = sel ? err3   : err1;
  assign rdata_m = sel ? rdata3 : rdata1;
  assign sclk_m  = sel ? sclk3  : sclk1;
  assign mosi_m  = sel ? mosi3  : mosi1;
  assign cs_n_m  = sel ? cs_n3  : {1'b1, cs_n1};

  spi_mem_master #(.NUM_CS(2), .ADDR_W(24), .MAX_BYTES(4), .CLK_DIV(1)) u_dut_d1 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(ready1),
    .req_write(req_write), .req_cs(req_cs[0:0]), .req_addr(req_addr), .req_len(req_len),
    .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_err(err1), .rsp_rdata(rdata1),
    .sclk(sclk1), .mosi(mosi1), .miso(miso), .cs_n(cs_n1)
  );

  spi_mem_master #(.NUM_CS(3), .ADDR_W(24), .MAX_BYTES(4), .CLK_DIV(3)) u_dut_d3 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(ready3),
    .req_write(req_write), .req_cs(req_cs), .req_addr(req_addr), .req_len(req_len),
    .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_err(err3), .rsp_rdata(rdata3),
    .sclk(sclk3), .mosi(mosi3), .miso(miso), .cs_n(cs_n3)
  );

  typedef struct {
    bit          sel;
    logic        write;
    logic [1:0]  cs;
    logic [23:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic [31:0] sdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_cs_n;
  } vec_t;

  typedef struct {
    int          lat;
    int          div;
    int          nbits;
    logic        err;
    logic [31:0] rdata;
    logic [63:0] mosi;
    logic [2:0]  cs_n;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Slave model and bus monitors state
  logic [31:0] slave_data = '0;
  logic [63:0] mosi_stream = '0;
  logic [2:0]  seen_cs = '1;
  logic        sclk_m_prev = 1'b0, sclk1_prev = 1'b0, sclk3_prev = 1'b0;
  bit          in_txn = 1'b0;
  int          bit_cnt = 0, run = 0, min_run = 0, max_run = 0;
  int          toggles = 0, cs_low_cnt = 0, multi_cs = 0;

  function automatic logic slave_bit(input int i, input logic [31:0] d);
    int j;
    if (i < 32) return 1'b0;
    j = i - 32;
    if (j >= 32) return 1'b0;
    return d[8*(j/8) + 7 - (j%8)];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      in_txn = 1'b0;
      miso   = 1'b0;
    end else begin
      if (sclk1 !== sclk1_prev) toggles++;
      if (sclk3 !== sclk3_prev) toggles++;
      if (cs_n1 != 2'b11 || cs_n3 != 3'b111) cs_low_cnt++;
      if ($countones(~cs_n1) > 1 || $countones(~cs_n3) > 1 ||
          (cs_n1 != 2'b11 && cs_n3 != 3'b111)) multi_cs++;
      if (cs_n_m == 3'b111) begin
        if (in_txn) begin
          if (run < min_run) min_run = run;
          if (run > max_run) max_run = run;
        end
        in_txn = 1'b0;
        miso   = 1'b0;
      end else begin
        if (!in_txn) begin
          in_txn = 1'b1; bit_cnt = 0; mosi_stream = '0; run = 1;
          min_run = 1000; max_run = 0; seen_cs = cs_n_m;
        end else begin
          if (sclk_m == sclk_m_prev) run++;
          else begin
            if (run < min_run) min_run = run;
            if (run > max_run) max_run = run;
            run = 1;
          end
          if (sclk_m && !sclk_m_prev) begin
            mosi_stream = {mosi_stream[62:0], mosi_m};
            bit_cnt++;
          end
        end
        miso = slave_bit(bit_cnt, slave_data);
      end
    end
    sclk_m_prev = sclk_m;
    sclk1_prev  = sclk1;
    sclk3_prev  = sclk3;
  end

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e, g;
    int   lat, tog0, low0, nb;
    bit   got, rdy;
    @(negedge clk);
    sel = v.sel; slave_data = v.sdata;
    req_write = v.write; req_cs = v.cs; req_addr = v.addr; req_len = v.len; req_wdata = v.wdata;
    req_valid = 1'b1;
    #1;
    rdy = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (ready_m) begin rdy = 1'b1; break; end
      @(negedge clk);
    end
    check($sformatf("v%0d_ready", idx), 64'(rdy), 64'd1);
    if (!rdy) begin req_valid = 1'b0; return; end

    nb      = v.exp_err ? 0 : 32 + 8 * int'(v.len);
    e.div   = v.sel ? 3 : 1;
    e.nbits = nb;
    e.err   = v.exp_err;
    e.rdata = v.exp_rdata;
    e.cs_n  = v.exp_cs_n;
    e.lat   = v.exp_err ? 0 : 2 * e.div * nb;
    e.mosi  = {56'h0, (v.write ? 8'h02 : 8'h03)};
    e.mosi  = (e.mosi << 24) | 64'(v.addr);
    if (!v.exp_err)
      for (int k = 0; k < int'(v.len); k++)
        e.mosi = (e.mosi << 8) | (v.write ? 64'(v.wdata[8*k +: 8]) : 64'h0);

    @(posedge clk);
    sb.push_back(e);
    tog0 = toggles; low0 = cs_low_cnt;
    @(negedge clk);
    // Request fields are don't-care after acceptance.
    req_valid = 1'b0; req_addr = 24'($urandom); req_len = 3'($urandom);
    req_cs = 2'($urandom); req_write = 1'($urandom); req_wdata = $urandom;
    #1;
    got = 1'b0; lat = 0;
    for (int k = 0; k < 4000; k++) begin
      if (rv_m) begin got = 1'b1; break; end
      @(negedge clk); #1;
      lat++;
    end
    check($sformatf("v%0d_rsp_seen", idx), 64'(got), 64'd1);
    if (!got) begin sb.delete(); return; end
    g = sb.pop_front();
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'(g.lat));
    check($sformatf("v%0d_err", idx), 64'(err_m), 64'(g.err));
    check($sformatf("v%0d_rdata", idx), 64'(rdata_m), 64'(g.rdata));
    if (!g.err) begin
      check($sformatf("v%0d_mosi", idx), mosi_stream, g.mosi);
      check($sformatf("v%0d_nbits", idx), 64'(bit_cnt), 64'(g.nbits));
      check($sformatf("v%0d_cs_n", idx), 64'(seen_cs), 64'(g.cs_n));
      check($sformatf("v%0d_min_phase", idx), 64'(min_run), 64'(g.div));
      check($sformatf("v%0d_max_phase", idx), 64'(max_run), 64'(g.div));
    end else begin
      check($sformatf("v%0d_no_sclk", idx), 64'(toggles - tog0), 64'd0);
      check($sformatf("v%0d_no_cs", idx), 64'(cs_low_cnt - low0), 64'd0);
    end
    @(negedge clk); #1;
    check($sformatf("v%0d_pulse", idx), 64'(rv_m), 64'd0);
    check($sformatf("v%0d_idle_ready", idx), 64'(ready_m), 64'd1);
    check($sformatf("v%0d_cs_released", idx), 64'(cs_n_m), 64'h7);
    check($sformatf("v%0d_rdata_hold", idx), 64'(rdata_m), 64'(g.rdata));
  endtask

  vec_t vecs[8];
  vec_t post_rst;
  int   tog0, rv_cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_cs = '0; req_addr = '0;
    req_len = '0; req_wdata = '0; sel = 1'b0;

    //         sel  wr    cs  addr        len wdata         sdata         err   rdata         cs_n
    vecs[0] = '{0, 1'b0, 0, 24'h000010, 4, 32'h0,        32'h93000513, 1'b0, 32'h93000513, 3'b110};
    vecs[1] = '{0, 1'b1, 1, 24'h0000FF, 2, 32'h0000BEEF, 32'hFFFFFFFF, 1'b0, 32'h0,        3'b101};
    vecs[2] = '{1, 1'b0, 0, 24'h000000, 1, 32'h0,        32'h000000A5, 1'b0, 32'h000000A5, 3'b110};
    vecs[3] = '{0, 1'b0, 0, 24'h000100, 0, 32'h0,        32'h0,        1'b1, 32'h0,        3'b111};
    vecs[4] = '{0, 1'b0, 1, 24'h000100, 5, 32'h0,        32'h0,        1'b1, 32'h0,        3'b111};
    vecs[5] = '{1, 1'b0, 3, 24'h000200, 2, 32'h0,        32'h0,        1'b1, 32'h0,        3'b111};
    vecs[6] = '{0, 1'b0, 1, 24'h123456, 3, 32'h0,        32'h11CCBBAA, 1'b0, 32'h00CCBBAA, 3'b101};
    vecs[7] = '{1, 1'b1, 2, 24'hABCDEF, 4, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0,        3'b011};
    post_rst = '{0, 1'b0, 0, 24'h000004, 1, 32'h0,       32'h0000007F, 1'b0, 32'h0000007F, 3'b110};

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready1), 64'd1);
    check("rst_rdata", 64'(rdata1), 64'd0);
    rst = 1'b0;
    tog0 = toggles;
    repeat (5) @(negedge clk);
    check("idle_ready_d1", 64'(ready1), 64'd1);
    check("idle_ready_d3", 64'(ready3), 64'd1);
    check("idle_cs_n_d1", 64'(cs_n1), 64'h3);
    check("idle_cs_n_d3", 64'(cs_n3), 64'h7);
    check("idle_sclk", 64'({sclk1, sclk3}), 64'd0);
    check("idle_mosi", 64'({mosi1, mosi3}), 64'd0);
    check("idle_rsp", 64'({rv1, err1, rv3, err3}), 64'd0);
    check("idle_rdata", 64'({rdata1, rdata3}), 64'd0);
    check("idle_no_toggle", 64'(toggles - tog0), 64'd0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a read: everything drops at once, no response.
    @(negedge clk);
    sel = 1'b0; slave_data = 32'h12345678;
    req_write = 1'b0; req_cs = 2'd0; req_addr = 24'h000040; req_len = 3'd4; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("mid_cs_active", 64'(cs_n1), 64'h2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cs_n", 64'(cs_n1), 64'h3);
    check("mid_rst_sclk", 64'(sclk1), 64'd0);
    check("mid_rst_rsp", 64'(rv1), 64'd0);
    check("mid_rst_ready", 64'(ready1), 64'd1);
    rst = 1'b0;
    rv_cnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (rv1) rv_cnt++;
    end
    check("mid_rst_no_rsp", 64'(rv_cnt), 64'd0);
    run_vec(8, post_rst);

    check("one_cs_at_a_time", 64'(multi_cs), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
